fwd_sched: RTL and testbench
============================

Name: fwd_sched

Overview:
- Per-port forwarding stage that consumes the 16-bit forwarding map and bonding mode produced by the command receiver.
- Drains this port's 9-bit RX FIFO frame by frame and replicates each frame into the TX FIFOs of the selected destination ports.
- In bonding mode, each frame goes to exactly one destination, chosen round-robin.
- One instance per physical port; it sits between the port's RX FIFO and the shared TX FIFO bank.

Parameters:
- PORT_NUM, 2'd0: index of this port; selects nibble cmd_fwd_port[4*PORT_NUM+3:4*PORT_NUM] as the destination mask.
- NPORT, 4: number of ports (fixed at 4; cmd_fwd_port is 4x4 bits).
- LOOPBACK, 1'b0: 0 = the self bit (bit PORT_NUM) is always cleared from the mask; 1 = the self bit is honoured.

Ports:
- sys_clk, in, 1: system clock.
- sys_rst_n, in, 1: asynchronous active-low reset.
- rx_dout, in, 9: FWFT RX FIFO head; bit8 = 1 for frame byte, 0 for gap/terminator; [7:0] = data.
- rx_empty, in, 1: RX FIFO empty.
- rx_rd_en, out, 1: pop RX FIFO; combinational.
- cmd_fwd_port, in, 16: forwarding map from the command receiver.
- cmd_mode, in, 1: 1 = bonding (single round-robin destination), 0 = replicate to every mask bit.
- tx_din, out, 9: data broadcast to all TX FIFOs; registered.
- tx_wr_en, out, 4: per-destination write strobes; registered.
- tx_afull, in, 4: TX FIFO almost-full; asserted with at least 2 free entries remaining.
- stat_fwd_cnt, out, 16: frames forwarded; wraps.
- stat_drop_cnt, out, 16: frames dropped (empty destination set); wraps.

Behaviour:
- Reset (async, sys_rst_n=0): state=SYNC; tx_wr_en=0; tx_din=0; stats=0; rr_ptr=PORT_NUM; latched dest/mode=0. rx_rd_en=0 while in reset.
- FWFT contract: rx_dout is valid whenever rx_empty=0. A pop occurs on any cycle with rx_rd_en=1, and rx_rd_en is never asserted when rx_empty=1.
- SYNC: pop every available entry and discard it. On popping an entry with bit8=0, go to IDLE. This guarantees that a reset in mid-frame never forwards a partial frame.
- IDLE, rx_empty=0, rx_dout[8]=0: pop and discard (inter-frame gap).
- IDLE, rx_dout[8]=1 (start of frame): do not pop. Compute and latch mask = nibble & (LOOPBACK ? 4'hF : ~(1<<PORT_NUM)), and latch mode=cmd_mode.
  - Bonding: dest = first set bit of mask searching upward (mod 4) from rr_ptr+1; rr_ptr <= index of that bit. rr_ptr is unchanged if mask=0.
  - Replicate: dest = mask.
  - dest=0: go to DROP and increment stat_drop_cnt. Otherwise go to FWD and increment stat_fwd_cnt.
  - Decision takes exactly 1 cycle; the first byte is popped no earlier than the following cycle.
- FWD, each cycle: pop iff rx_empty=0 and (tx_afull & dest)==0.
  - On a pop, the next cycle has tx_din=rx_dout and tx_wr_en=dest (latency 1).
  - A popped entry with bit8=0 is the terminator. It is written to the destinations as well, then the state goes to IDLE.
  - The frame byte stream reaches every destination identically. A stall on any destination stalls all of them; bytes are never split per port.
- DROP: pop every available entry without writing; the popped bit8=0 terminator returns the state to IDLE.
- Changes on cmd_fwd_port or cmd_mode while in FWD/DROP are ignored until the next start of frame.
- tx_wr_en is 0 on every cycle that did not follow a FWD pop. tx_din holds its last value.
- Stats counters wrap from 16'hFFFF to 16'h0000.

Decomposition:
- Package fwd_sched_pkg: state enum {SYNC, IDLE, FWD, DROP}, NPORT, data width 9, and the frame-flag bit index 8.
- One sub-module, rr_pick: combinational 4-bit round-robin picker with inputs mask and ptr, outputs onehot and idx. It is reused by the future TX arbiter.

Test Plan:
- Reset, then frame of 60 bytes, PORT_NUM=0, nibble=4'hE, mode=0: 61 writes (60 bytes + terminator), each with tx_wr_en=4'hE and bytes identical to the input; stat_fwd_cnt=1.
- Nibble=4'h1, PORT_NUM=0, LOOPBACK=0: frame is fully popped with no tx_wr_en asserted; stat_drop_cnt=1; the next frame is handled normally.
- Bonding, nibble=4'hE, 4 frames back to back: tx_wr_en sequence 4'h2, 4'h4, 4'h8, 4'h2.
- tx_afull[2] held high for 10 cycles mid-frame with dest=4'h6: rx_rd_en=0 for those cycles; no writes to either port; the stream resumes in order with no loss or duplicate.
- sys_rst_n pulsed low at byte 20 of a frame: outputs clear immediately; the remainder of the frame is discarded in SYNC; the next frame is forwarded intact.
- cmd_fwd_port changes from nibble 4'h2 to 4'h4 at byte 5: the entire frame still goes to 4'h2, and the next frame goes to 4'h4.

Source files
------------

// File: rtl/fwd_sched_pkg.sv
// Shared types and constants for the per-port forwarding scheduler.
// The frame-flag bit separates frame bytes (1) from gaps/terminators (0).
package fwd_sched_pkg;

  localparam int NPORT    = 4;
  localparam int DATA_W   = 9;
  localparam int FLAG_BIT = 8;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    FWD  = 2'd2,
    DROP = 2'd3
  } state_t;

endpackage

// File: rtl/fwd_sched_if.sv
// RX FIFO read side and TX FIFO bank write side of one forwarding port.
// master = the scheduler, slave = the FIFO bank.
interface fwd_sched_if;
  import fwd_sched_pkg::*;

  logic [DATA_W-1:0] rx_dout;
  logic              rx_empty;
  logic              rx_rd_en;
  logic [DATA_W-1:0] tx_din;
  logic [NPORT-1:0]  tx_wr_en;
  logic [NPORT-1:0]  tx_afull;

  modport master (
    input  rx_dout, rx_empty, tx_afull,
    output rx_rd_en, tx_din, tx_wr_en
  );

  modport slave (
    output rx_dout, rx_empty, tx_afull,
    input  rx_rd_en, tx_din, tx_wr_en
  );

endinterface

// File: rtl/fwd_sched_rr_pick.sv
// Combinational 4-way round-robin picker: first set bit of mask searching
// upward (mod 4) starting one past ptr.
module rr_pick (
  input  logic [3:0] mask,
  input  logic [1:0] ptr,
  output logic [3:0] onehot,
  output logic [1:0] idx
);

  logic [1:0] cand_s;
  logic       found_s;

  // Scan ptr+1 .. ptr+4; the current holder is considered last.
  always_comb begin
    onehot  = 4'b0000;
    idx     = ptr;
    cand_s  = ptr;
    found_s = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand_s = ptr + 2'(i);
      if (!found_s && mask[cand_s]) begin
        found_s        = 1'b1;
        idx            = cand_s;
        onehot[cand_s] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/fwd_sched.sv
// Per-port forwarding stage: drains the RX FIFO frame by frame and replicates
// each frame to the selected TX FIFOs (or one round-robin port in bonding mode).
module fwd_sched
  import fwd_sched_pkg::*;
#(
  parameter logic [1:0] PORT_NUM = 2'd0,
  parameter int         NPORT    = 4,
  parameter logic       LOOPBACK = 1'b0
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  fwd_sched_if.master        ports,
  input  logic [4*NPORT-1:0] cmd_fwd_port,
  input  logic               cmd_mode,
  output logic [15:0]        stat_fwd_cnt,
  output logic [15:0]        stat_drop_cnt
);

  state_t            state_r;
  logic [3:0]        dest_r;
  logic [1:0]        rr_ptr_r;
  logic [DATA_W-1:0] tx_din_r;
  logic [3:0]        tx_wr_en_r;
  logic [15:0]       fwd_cnt_r;
  logic [15:0]       drop_cnt_r;

  logic [3:0]        nibble_s;
  logic [3:0]        self_mask_s;
  logic [3:0]        mask_s;
  logic [3:0]        pick_onehot_s;
  logic [1:0]        pick_idx_s;
  logic [3:0]        dest_next_s;
  logic              rd_en_s;
  logic              flag_s;
  logic              sof_s;

  assign nibble_s    = cmd_fwd_port[4*int'(PORT_NUM) +: 4];
  assign self_mask_s = LOOPBACK ? 4'hF : ~(4'b0001 << PORT_NUM);
  assign mask_s      = nibble_s & self_mask_s;
  assign dest_next_s = cmd_mode ? pick_onehot_s : mask_s;
  assign flag_s      = ports.rx_dout[FLAG_BIT];
  assign sof_s       = (state_r == IDLE) && !ports.rx_empty && flag_s;

  rr_pick u_rr_pick (
    .mask   (mask_s),
    .ptr    (rr_ptr_r),
    .onehot (pick_onehot_s),
    .idx    (pick_idx_s)
  );

  // Pop decision; in FWD a single almost-full destination stalls the whole stream.
  always_comb begin
    rd_en_s = 1'b0;
    case (state_r)
      SYNC:    rd_en_s = !ports.rx_empty;
      IDLE:    rd_en_s = !ports.rx_empty && !flag_s;
      FWD:     rd_en_s = !ports.rx_empty && ((ports.tx_afull & dest_r) == 4'b0000);
      DROP:    rd_en_s = !ports.rx_empty;
      default: rd_en_s = 1'b0;
    endcase
  end

  assign ports.rx_rd_en = rd_en_s & sys_rst_n;
  assign ports.tx_din   = tx_din_r;
  assign ports.tx_wr_en = tx_wr_en_r;
  assign stat_fwd_cnt   = fwd_cnt_r;
  assign stat_drop_cnt  = drop_cnt_r;

  // Frame FSM, output registers and statistics.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r    <= SYNC;
      dest_r     <= 4'b0000;
      rr_ptr_r   <= PORT_NUM;
      tx_din_r   <= '0;
      tx_wr_en_r <= 4'b0000;
      fwd_cnt_r  <= 16'd0;
      drop_cnt_r <= 16'd0;
    end else begin
      tx_wr_en_r <= ((state_r == FWD) && rd_en_s) ? dest_r : 4'b0000;
      if ((state_r == FWD) && rd_en_s) begin
        tx_din_r <= ports.rx_dout;
      end

      case (state_r)
        SYNC: begin
          if (rd_en_s && !flag_s) begin
            state_r <= IDLE;
          end
        end
        IDLE: begin
          // Map and mode are sampled only here; later changes wait for the next frame.
          if (sof_s) begin
            dest_r <= dest_next_s;
            if (cmd_mode && (mask_s != 4'b0000)) begin
              rr_ptr_r <= pick_idx_s;
            end
            if (dest_next_s == 4'b0000) begin
              state_r    <= DROP;
              drop_cnt_r <= drop_cnt_r + 16'd1;
            end else begin
              state_r   <= FWD;
              fwd_cnt_r <= fwd_cnt_r + 16'd1;
            end
          end
        end
        FWD, DROP: begin
          if (rd_en_s && !flag_s) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_fwd_sched.sv
// Directed bench for fwd_sched (PORT_NUM=0, LOOPBACK=0) with a FWFT RX FIFO
// model and a capture queue of every TX write.
module tb_fwd_sched;
  import fwd_sched_pkg::*;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [15:0] cmd_fwd_port = 16'h0000;
  logic        cmd_mode = 1'b0;
  logic [15:0] stat_fwd_cnt;
  logic [15:0] stat_drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0]  rxq[$];
  logic [12:0] exp_q[$];
  logic [12:0] cap_q[$];

  fwd_sched_if ifc ();

  fwd_sched #(.PORT_NUM(2'd0), .NPORT(4), .LOOPBACK(1'b0)) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .ports         (ifc.master),
    .cmd_fwd_port  (cmd_fwd_port),
    .cmd_mode      (cmd_mode),
    .stat_fwd_cnt  (stat_fwd_cnt),
    .stat_drop_cnt (stat_drop_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  // FWFT RX FIFO model: pop on the edge, present the new head after it.
  always @(posedge sys_clk) begin
    if (ifc.rx_rd_en && rxq.size() > 0) begin
      void'(rxq.pop_front());
    end
    ifc.rx_empty <= (rxq.size() == 0);
    ifc.rx_dout  <= (rxq.size() > 0) ? rxq[0] : 9'h000;
  end

  // Capture every TX write away from the active edge.
  always @(negedge sys_clk) begin
    if (sys_rst_n && ifc.tx_wr_en != 4'b0000) begin
      cap_q.push_back({ifc.tx_wr_en, ifc.tx_din});
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h want=%0h", tag, act, exp);
    end
  endtask

  task automatic push_frame(input int len, input logic [7:0] seed, input logic [3:0] dest);
    logic [8:0] e;
    for (int i = 0; i < len; i++) begin
      e = {1'b1, seed + 8'(i * 7)};
      rxq.push_back(e);
      if (dest != 4'b0000) exp_q.push_back({dest, e});
    end
    e = {1'b0, seed ^ 8'hFF};
    rxq.push_back(e);
    if (dest != 4'b0000) exp_q.push_back({dest, e});
  endtask

  task automatic wait_cap(input int n, input int budget);
    int k = 0;
    while (cap_q.size() < n && k < budget) begin
      @(negedge sys_clk);
      k++;
    end
    if (k >= budget) chk("wait_cap_timeout", 32'(cap_q.size()), 32'(n));
  endtask

  // Wait for the RX queue to drain and all expected writes, then compare in order.
  task automatic verify(input string tag);
    int k = 0;
    while ((rxq.size() > 0 || cap_q.size() < exp_q.size()) && k < 2000) begin
      @(negedge sys_clk);
      k++;
    end
    if (k >= 2000) chk({tag, "_timeout"}, 32'(k), 32'd0);
    repeat (6) @(negedge sys_clk);
    chk({tag, "_nwr"}, 32'(cap_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
      chk({tag, "_wr"}, 32'(cap_q[i]), 32'(exp_q[i]));
    end
    cap_q.delete();
    exp_q.delete();
  endtask

  initial begin
    ifc.rx_empty = 1'b1;
    ifc.rx_dout  = 9'h000;
    ifc.tx_afull = 4'b0000;
    cmd_fwd_port = 16'h3C5E;
    cmd_mode     = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("rst_wr_en", 32'(ifc.tx_wr_en), 32'h0);
    chk("rst_din", 32'(ifc.tx_din), 32'h0);
    chk("rst_fwd", 32'(stat_fwd_cnt), 32'h0);
    chk("rst_drop", 32'(stat_drop_cnt), 32'h0);
    chk("rst_rd_en", 32'(ifc.rx_rd_en), 32'h0);
    sys_rst_n = 1'b1;

    // Replicate a 60-byte frame to ports 1..3 (gap first to leave SYNC).
    rxq.push_back(9'h000);
    push_frame(60, 8'h10, 4'hE);
    verify("rep60");
    chk("rep60_fwd", 32'(stat_fwd_cnt), 32'd1);

    // Self-only map is dropped, next frame forwarded normally.
    cmd_fwd_port = 16'hFFF1;
    push_frame(10, 8'h40, 4'h0);
    verify("drop");
    chk("drop_cnt", 32'(stat_drop_cnt), 32'd1);
    cmd_fwd_port = 16'h0002;
    push_frame(5, 8'h55, 4'h2);
    verify("after_drop");
    chk("after_drop_fwd", 32'(stat_fwd_cnt), 32'd2);

    // Bonding round robin starting after rr_ptr=0.
    cmd_fwd_port = 16'h000E;
    cmd_mode     = 1'b1;
    push_frame(3, 8'h01, 4'h2);
    push_frame(3, 8'h21, 4'h4);
    push_frame(3, 8'h41, 4'h8);
    push_frame(3, 8'h61, 4'h2);
    verify("bond");
    chk("bond_fwd", 32'(stat_fwd_cnt), 32'd6);

    // Stall on one destination stalls the whole stream.
    cmd_mode     = 1'b0;
    cmd_fwd_port = 16'h0006;
    push_frame(30, 8'h80, 4'h6);
    wait_cap(10, 200);
    ifc.tx_afull = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      chk("stall_rd_en", 32'(ifc.rx_rd_en), 32'h0);
      chk("stall_wr_en", 32'(ifc.tx_wr_en), 32'h0);
    end
    ifc.tx_afull = 4'b0000;
    verify("stall");

    // Reset mid-frame: remainder discarded, next frame intact.
    cmd_fwd_port = 16'h0002;
    push_frame(40, 8'hA0, 4'h0);
    push_frame(8, 8'hC3, 4'h2);
    wait_cap(20, 200);
    sys_rst_n = 1'b0;
    #1;
    chk("mrst_wr_en", 32'(ifc.tx_wr_en), 32'h0);
    chk("mrst_din", 32'(ifc.tx_din), 32'h0);
    chk("mrst_fwd", 32'(stat_fwd_cnt), 32'h0);
    chk("mrst_rd_en", 32'(ifc.rx_rd_en), 32'h0);
    repeat (2) @(negedge sys_clk);
    cap_q.delete();
    sys_rst_n = 1'b1;
    verify("mrst");
    chk("mrst_fwd_after", 32'(stat_fwd_cnt), 32'd1);

    // Map change mid-frame only affects the next frame.
    push_frame(12, 8'h31, 4'h2);
    push_frame(6, 8'h71, 4'h4);
    wait_cap(5, 200);
    cmd_fwd_port = 16'h0004;
    verify("remap");
    chk("remap_fwd", 32'(stat_fwd_cnt), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
